vga_timing: RTL and testbench
=============================

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, meaning active pixels per line.
REQ-002 SHALL have parameters H_FRONT, H_SYNC and H_BACK, defaults 16, 96 and 48, meaning horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_VISIBLE, default 480, meaning active lines per frame.
REQ-004 SHALL have parameters V_FRONT, V_SYNC and V_BACK, defaults 10, 2 and 33, meaning vertical porch and sync widths in lines.
REQ-005 SHALL have parameter LOCK_WAIT, default 16, meaning the number of consecutive synchronized-locked cycles required before timing starts.
REQ-006 SHALL have port clk, input, 1 bit: pixel clock from the PLL global output; this is the only clock.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port locked, input, 1 bit: PLL lock indicator, treated as asynchronous to clk.
REQ-009 SHALL have port hsync, output, 1 bit: horizontal sync, active-low.
REQ-010 SHALL have port vsync, output, 1 bit: vertical sync, active-low.
REQ-011 SHALL have port de, output, 1 bit: data enable, high in the visible region.
REQ-012 SHALL have port x, output, 10 bits: current horizontal pixel position.
REQ-013 SHALL have port y, output, 10 bits: current line position.
REQ-014 SHALL have port line_start, output, 1 bit: one-cycle pulse when x==0.
REQ-015 SHALL have port frame_start, output, 1 bit: one-cycle pulse when x==0 and y==0.
REQ-016 SHALL have port frame_count, output, 16 bits: number of completed frames.
REQ-017 SHALL have port running, output, 1 bit: high while in state RUN.

Function
REQ-018 SHALL pass locked through a 2-flop synchronizer; all lock decisions SHALL use the synchronized value locked_s.
REQ-019 SHALL implement states WAIT_LOCK, SETTLE and RUN.
REQ-020 SHALL, in WAIT_LOCK, move to SETTLE when locked_s==1 and clear the settle counter.
REQ-021 SHALL, in SETTLE, increment the settle counter each cycle locked_s==1, return to WAIT_LOCK on locked_s==0, and enter RUN on the edge after the counter reaches LOCK_WAIT.
REQ-022 SHALL, in RUN, return to WAIT_LOCK on the first edge at which locked_s==0; that edge SHALL also force the idle outputs.
REQ-023 Idle outputs (any state other than RUN) SHALL be hsync=1, vsync=1, de=0, x=0, y=0, line_start=0, frame_start=0 and running=0.
REQ-024 H_TOTAL SHALL equal the sum of the four H parameters and V_TOTAL the sum of the four V parameters; elaboration SHALL fail if either total exceeds 1024.
REQ-025 In RUN, x SHALL increment once per clk and wrap from H_TOTAL-1 to 0; y SHALL increment only on x wrap and wrap from V_TOTAL-1 to 0.
REQ-026 All outputs SHALL be registered and SHALL describe the same pixel (x,y) in the same cycle, with zero skew between outputs.
REQ-027 de SHALL be 1 iff x<H_VISIBLE and y<V_VISIBLE.
REQ-028 hsync SHALL be 0 iff H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC.
REQ-029 vsync SHALL be 0 iff V_VISIBLE+V_FRONT <= y < V_VISIBLE+V_FRONT+V_SYNC.
REQ-030 The first RUN cycle SHALL present x=0, y=0, de=1, line_start=1 and frame_start=1.
REQ-031 RUN re-entry after lock loss SHALL always restart at x=0, y=0; no partial frame SHALL resume.

Reset
REQ-032 rst_n low SHALL asynchronously force state WAIT_LOCK, both synchronizer flops to 0, the settle counter to 0, frame_count to 0 and all outputs to the idle values.
REQ-033 Reset release SHALL be synchronous to clk; the first state change SHALL occur no earlier than 2 edges after deassertion.

Configuration
REQ-034 With macro VGA_TIMING_FRAME_CNT_EN defined, frame_count SHALL increment, wrapping modulo 2^16, on each x/y wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0); it SHALL hold through lock loss and clear only on rst_n.
REQ-035 Without VGA_TIMING_FRAME_CNT_EN, frame_count SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification
REQ-036 Reset check: rst_n=0 with locked=1 -> hsync=1, vsync=1, de=0, x=0, y=0, running=0, frame_count=0.
REQ-037 Lock start-up: locked rises and is first sampled at edge k with LOCK_WAIT=16 -> running=1, de=1 and frame_start=1 after edge k+18.
REQ-038 Lock glitch: locked low for 1 cycle during SETTLE -> settle restarts and RUN entry is delayed by the full 16 cycles plus synchronizer latency.
REQ-039 Line timing: de high for x in 0..639, hsync low for x in 656..751, x wraps from 799 to 0 with y+1 and line_start=1.
REQ-040 Frame timing: vsync low for y in 490..491; at (799,524) -> next cycle (0,0) with frame_start=1 and frame_count incremented by 1 (with VGA_TIMING_FRAME_CNT_EN defined).
REQ-041 Lock loss: locked dropped at (300,200) -> idle outputs 2 edges after sampling; relock -> restart at (0,0) with frame_count unchanged.

Source files
------------

// File: rtl/vga_timing_if.sv
// Video timing bundle produced by vga_timing: syncs, data enable, pixel position and status.
// Master drives the timing; slave consumes it (pixel generator, scan-out, monitors).
interface vga_timing_if;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        line_start;
  logic        frame_start;
  logic [15:0] frame_count;
  logic        running;

  modport master (
    output hsync, vsync, de, x, y, line_start, frame_start, frame_count, running
  );

  modport slave (
    input hsync, vsync, de, x, y, line_start, frame_start, frame_count, running
  );
endinterface

// File: rtl/vga_timing.sv
// VGA raster timing generator gated by a synchronized PLL lock; all outputs registered together.
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int LOCK_WAIT = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         locked,
  vga_timing_if.master vid
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int CNT_W    = (LOCK_WAIT < 2) ? 1 : $clog2(LOCK_WAIT + 1);

  localparam logic [9:0]       X_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0]       Y_LAST      = 10'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(LOCK_WAIT - 1);

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_too_large
      $error("vga_timing: H_TOTAL or V_TOTAL exceeds the 10-bit position range");
    end
  endgenerate

  typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [1:0]       sync_q;
  logic             locked_s;
  logic [CNT_W-1:0] settle_q, settle_d;

  logic [9:0] x_q, x_d, y_q, y_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic       line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic       running_q, running_d;

  assign locked_s = sync_q[1];

  // Lock sequencing; position and decodes are computed from the next state so every output lands together
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d  = SETTLE;
          settle_d = '0;
        end
      end
      SETTLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else begin
          settle_d = settle_q + 1'b1;
          if (settle_q == SETTLE_LAST) state_d = RUN;
        end
      end
      RUN: begin
        if (!locked_s) state_d = WAIT_LOCK;
      end
      default: state_d = WAIT_LOCK;
    endcase

    x_d = '0;
    y_d = '0;
    if (state_q == RUN && state_d == RUN) begin
      if (x_q == X_LAST) begin
        if (y_q != Y_LAST) y_d = y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
        y_d = y_q;
      end
    end

    running_d     = (state_d == RUN);
    de_d          = running_d && ({1'b0, x_d} < 11'(H_VISIBLE)) && ({1'b0, y_d} < 11'(V_VISIBLE));
    hsync_d       = !(running_d && ({1'b0, x_d} >= 11'(HS_START)) && ({1'b0, x_d} < 11'(HS_END)));
    vsync_d       = !(running_d && ({1'b0, y_d} >= 11'(VS_START)) && ({1'b0, y_d} < 11'(VS_END)));
    line_start_d  = running_d && (x_d == 10'd0);
    frame_start_d = line_start_d && (y_d == 10'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q        <= 2'b00;
      state_q       <= WAIT_LOCK;
      settle_q      <= '0;
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      sync_q        <= {sync_q[0], locked};
      state_q       <= state_d;
      settle_q      <= settle_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      running_q     <= running_d;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic        frame_wrap;
  logic [15:0] frame_cnt_q;

  // Counts only the natural (H_TOTAL-1, V_TOTAL-1) -> (0,0) wrap; lock loss leaves it untouched
  assign frame_wrap = (state_q == RUN) && (state_d == RUN) && (x_q == X_LAST) && (y_q == Y_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else if (frame_wrap) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign vid.frame_count = frame_cnt_q;
`else
  assign vid.frame_count = '0;
`endif

  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.de          = de_q;
  assign vid.x           = x_q;
  assign vid.y           = y_q;
  assign vid.line_start  = line_start_q;
  assign vid.frame_start = frame_start_q;
  assign vid.running     = running_q;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing on a reduced 32x15 raster: lock start-up, line/frame timing,
// lock loss, settle glitch and asynchronous reset, checked through an expectation queue.
module tb_vga_timing;

  localparam int HV = 16, HF = 4, HS = 6, HB = 6;
  localparam int VV = 8,  VF = 2, VS = 2, VB = 3;
  localparam int LW = 16;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;

  typedef enum int {S_HS, S_VS, S_DE, S_X, S_Y, S_LS, S_FS, S_FC, S_RUN} sig_e;
  typedef struct {
    sig_e        sel;
    logic [15:0] exp;
  } item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic locked = 1'b0;

  item_t       sb[$];
  int          n_asserts = 0;
  int          n_fail = 0;
  logic [15:0] fc_exp = 16'd0;
  int          px = 0;
  int          py = 0;

  vga_timing_if vif();

  vga_timing #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .LOCK_WAIT(LW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .locked (locked),
    .vid    (vif)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] obs(sig_e s);
    case (s)
      S_HS:    return {15'd0, vif.hsync};
      S_VS:    return {15'd0, vif.vsync};
      S_DE:    return {15'd0, vif.de};
      S_X:     return {6'd0, vif.x};
      S_Y:     return {6'd0, vif.y};
      S_LS:    return {15'd0, vif.line_start};
      S_FS:    return {15'd0, vif.frame_start};
      S_FC:    return vif.frame_count;
      default: return {15'd0, vif.running};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input sig_e s, input logic [15:0] v);
    item_t it;
    it.sel = s;
    it.exp = v;
    sb.push_back(it);
  endtask

  task automatic push_idle();
    push(S_HS, 16'd1); push(S_VS, 16'd1); push(S_DE, 16'd0);
    push(S_X, 16'd0);  push(S_Y, 16'd0);  push(S_LS, 16'd0);
    push(S_FS, 16'd0); push(S_RUN, 16'd0); push(S_FC, fc_exp);
  endtask

  task automatic push_pixel(input int xx, input int yy);
    push(S_X, 16'(xx));
    push(S_Y, 16'(yy));
    push(S_DE, (xx < HV && yy < VV) ? 16'd1 : 16'd0);
    push(S_HS, (xx >= HV + HF && xx < HV + HF + HS) ? 16'd0 : 16'd1);
    push(S_VS, (yy >= VV + VF && yy < VV + VF + VS) ? 16'd0 : 16'd1);
    push(S_LS, (xx == 0) ? 16'd1 : 16'd0);
    push(S_FS, (xx == 0 && yy == 0) ? 16'd1 : 16'd0);
    push(S_RUN, 16'd1);
    push(S_FC, fc_exp);
  endtask

  task automatic check_all();
    item_t       it;
    logic [15:0] o;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      o  = obs(it.sel);
      n_asserts++;
      assert (o === it.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d at x=%0d y=%0d", it.sel.name(), o, it.exp, px, py);
      end
    end
  endtask

  task automatic step_idle();
    push_idle();
    tick();
    check_all();
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      if (px == HT - 1) begin
        px = 0;
        if (py == VT - 1) begin
          py = 0;
`ifdef VGA_TIMING_FRAME_CNT_EN
          fc_exp = fc_exp + 16'd1;
`endif
        end else begin
          py = py + 1;
        end
      end else begin
        px = px + 1;
      end
      push_pixel(px, py);
      tick();
      check_all();
    end
  endtask

  // locked is already high before the first sampling edge k; RUN appears after edge k+18
  task automatic startup();
    repeat (18) step_idle();
    px = 0;
    py = 0;
    push_pixel(0, 0);
    tick();
    check_all();
  endtask

  initial begin
    rst_n  = 1'b0;
    locked = 1'b1;
    repeat (3) step_idle();

    rst_n = 1'b1;
    startup();

    run_cycles(HT * VT + HT * 5 + 10);

    locked = 1'b0;
    run_cycles(2);
    repeat (4) step_idle();

    locked = 1'b1;
    startup();
    run_cycles(40);

    locked = 1'b0;
    run_cycles(2);
    repeat (4) step_idle();
    locked = 1'b1;
    repeat (9) step_idle();
    locked = 1'b0;
    step_idle();
    locked = 1'b1;
    startup();

    run_cycles(HT * VT + 3);

    #2;
    rst_n  = 1'b0;
    #1;
    fc_exp = 16'd0;
    px     = 0;
    py     = 0;
    push_idle();
    check_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
